// File: rtl/ext_irq_controller.sv
// External interrupt controller: latches up to 8 peripheral lines, presents the
// highest-priority enabled one to the core, tracks claim/complete. Option: IRQ_SYNC_EN.
module ext_irq_controller #(
    parameter int          NUM_SRC   = 8,
    parameter logic [7:0]  EDGE_MASK = 8'hFF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_irq_src,
    input  logic [NUM_SRC-1:0] i_src_en,
    input  logic               i_claim,
    input  logic               i_complete,
    output logic               o_meip,
    output logic               o_e_irq,
    output logic [3:0]         o_vecto_no,
    output logic [NUM_SRC-1:0] o_pending,
    output logic               o_busy,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [NUM_SRC-1:0] EDGE_SRC = EDGE_MASK[NUM_SRC-1:0];

    state_t             state;
    logic [2:0]         sel_id;
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] cand;
    logic               sel_vld;
    logic [2:0]         sel_k;
    logic               claim_hit;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= i_irq_src;
            sync_q2 <= sync_q1;
        end
    end

    assign src = sync_q2;
`else
    assign src = i_irq_src;
`endif

    // src_prev keeps tracking the lines through reset, so a line already high
    // when reset releases is not mistaken for a fresh rising edge.
    always_ff @(posedge i_clk) begin
        src_prev <= src;
    end

    assign edge_det  = src & ~src_prev;
    assign cand      = pending & i_src_en;
    assign claim_hit = (state == REQUEST) && i_claim;

    always_comb begin
        sel_vld = 1'b0;
        sel_k   = 3'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (cand[k]) begin
                sel_vld = 1'b1;
                sel_k   = 3'(k);
            end
        end
    end

    // Edge sources: a new edge beats the claim clear. Level sources follow the
    // line except while they are the one in service.
    always_comb begin
        pend_nxt = pending;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (EDGE_SRC[k]) begin
                if (edge_det[k])
                    pend_nxt[k] = 1'b1;
                else if (claim_hit && (sel_id == 3'(k)))
                    pend_nxt[k] = 1'b0;
            end else if (!((state == SERVICE) && (sel_id == 3'(k)))) begin
                pend_nxt[k] = src[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            sel_id     <= 3'd0;
            pending    <= '0;
            o_meip     <= 1'b0;
            o_e_irq    <= 1'b0;
            o_vecto_no <= 4'd0;
            o_busy     <= 1'b0;
        end else begin
            pending <= pend_nxt;
            o_e_irq <= 1'b0;
            case (state)
                IDLE: begin
                    o_meip     <= 1'b0;
                    o_vecto_no <= 4'd0;
                    o_busy     <= 1'b0;
                    if (sel_vld) begin
                        sel_id     <= sel_k;
                        o_e_irq    <= 1'b1;
                        o_meip     <= 1'b1;
                        o_vecto_no <= {1'b0, sel_k} + 4'd1;
                        state      <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (i_claim) begin
                        o_meip <= 1'b0;
                        o_busy <= 1'b1;
                        state  <= SERVICE;
                    end else if (!cand[sel_id]) begin
                        o_meip     <= 1'b0;
                        o_vecto_no <= 4'd0;
                        state      <= IDLE;
                    end
                end
                SERVICE: begin
                    if (i_complete) begin
                        o_busy     <= 1'b0;
                        o_vecto_no <= 4'd0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    o_meip     <= 1'b0;
                    o_vecto_no <= 4'd0;
                    o_busy     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign o_pending = pending;
    assign o_state   = state;

endmodule

// File: tb/tb_ext_irq_controller.sv
// Directed bench for ext_irq_controller: one all-edge instance and one with
// source 0 level triggered, stepped through hand-computed cycles.
module tb_ext_irq_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_src, a_en;
    logic       a_claim, a_complete;
    logic       a_meip, a_e_irq, a_busy;
    logic [3:0] a_vec;
    logic [7:0] a_pend;
    logic [1:0] a_state;
    logic [7:0] b_src, b_en;
    logic       b_claim, b_complete;
    logic       b_meip, b_e_irq, b_busy;
    logic [3:0] b_vec;
    logic [7:0] b_pend;
    logic [1:0] b_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ext_irq_controller #(.NUM_SRC(8), .EDGE_MASK(8'hFF)) u_edge (
        .i_clk(clk), .i_rst(rst), .i_irq_src(a_src), .i_src_en(a_en),
        .i_claim(a_claim), .i_complete(a_complete), .o_meip(a_meip),
        .o_e_irq(a_e_irq), .o_vecto_no(a_vec), .o_pending(a_pend),
        .o_busy(a_busy), .o_state(a_state)
    );

    ext_irq_controller #(.NUM_SRC(8), .EDGE_MASK(8'hFE)) u_level (
        .i_clk(clk), .i_rst(rst), .i_irq_src(b_src), .i_src_en(b_en),
        .i_claim(b_claim), .i_complete(b_complete), .o_meip(b_meip),
        .o_e_irq(b_e_irq), .o_vecto_no(b_vec), .o_pending(b_pend),
        .o_busy(b_busy), .o_state(b_state)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // meip, e_irq, vector, busy in one call
    task automatic chk_a(input string tag, input logic m, input logic e,
                         input logic [3:0] v, input logic b);
        chk({tag, ".meip"}, {7'd0, a_meip}, {7'd0, m});
        chk({tag, ".e_irq"}, {7'd0, a_e_irq}, {7'd0, e});
        chk({tag, ".vec"}, {4'd0, a_vec}, {4'd0, v});
        chk({tag, ".busy"}, {7'd0, a_busy}, {7'd0, b});
    endtask

    initial begin
        rst = 1'b1;
        a_src = 8'hFF; a_en = 8'hFF; a_claim = 1'b0; a_complete = 1'b0;
        b_src = 8'hFF; b_en = 8'hFF; b_claim = 1'b0; b_complete = 1'b0;
        tick(2);
        chk_a("rst", 1'b0, 1'b0, 4'd0, 1'b0);
        chk("rst.pend", a_pend, 8'h00);
        chk("rst.state", {6'd0, a_state}, 8'd0);
        chk("rst.b_pend", b_pend, 8'h00);

        // Lines held high through reset release: no edge, no request.
        rst = 1'b0; b_src = 8'h00;
        tick(3);
        chk_a("post_rst", 1'b0, 1'b0, 4'd0, 1'b0);
        chk("post_rst.pend", a_pend, 8'h00);
        a_src = 8'h00;
        tick();

        // Single edge on source 2.
        a_src = 8'h04;
        tick();
        chk("single.pend", a_pend, 8'h04);
        chk("single.meip_e", {7'd0, a_meip}, 8'd0);
        tick();
        chk_a("single.req", 1'b1, 1'b1, 4'd3, 1'b0);
        chk("single.state", {6'd0, a_state}, 8'd1);
        tick();
        chk_a("single.req2", 1'b1, 1'b0, 4'd3, 1'b0);
        a_claim = 1'b1;
        tick();
        a_claim = 1'b0;
        chk_a("single.svc", 1'b0, 1'b0, 4'd3, 1'b1);
        chk("single.svc_pend", a_pend, 8'h00);
        a_claim = 1'b1;
        tick();
        a_claim = 1'b0;
        chk("single.claim_in_svc", {6'd0, a_state}, 8'd2);
        a_complete = 1'b1;
        tick();
        a_complete = 1'b0;
        chk_a("single.idle", 1'b0, 1'b0, 4'd0, 1'b0);
        a_src = 8'h00;
        tick();

        // Priority: sources 5 and 1 together.
        a_src = 8'h22;
        tick();
        chk("prio.pend", a_pend, 8'h22);
        tick();
        chk_a("prio.req1", 1'b1, 1'b1, 4'd2, 1'b0);
        a_claim = 1'b1;
        tick();
        a_claim = 1'b0;
        chk("prio.pend_after", a_pend, 8'h20);
        a_complete = 1'b1;
        tick();
        a_complete = 1'b0;
        chk_a("prio.idle", 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        chk_a("prio.req2", 1'b1, 1'b1, 4'd6, 1'b0);
        // claim and complete together in REQUEST: claim only
        a_claim = 1'b1; a_complete = 1'b1;
        tick();
        a_claim = 1'b0; a_complete = 1'b0;
        chk_a("prio.both", 1'b0, 1'b0, 4'd6, 1'b1);
        chk("prio.both_state", {6'd0, a_state}, 8'd2);
        a_complete = 1'b1;
        tick();
        a_complete = 1'b0;
        chk("prio.pend_end", a_pend, 8'h00);
        a_src = 8'h00;
        tick();
        chk_a("prio.quiet", 1'b0, 1'b0, 4'd0, 1'b0);

        // Masking: source 4 disabled latches but is not selected.
        a_en = 8'hEF; a_src = 8'h10;
        tick();
        chk("mask.pend", a_pend, 8'h10);
        tick(2);
        chk("mask.meip_off", {7'd0, a_meip}, 8'd0);
        a_en = 8'hFF;
        tick();
        chk_a("mask.req", 1'b1, 1'b1, 4'd5, 1'b0);
        // Higher-priority arrival does not preempt
        a_src = 8'h11;
        tick();
        chk("nopre.pend", a_pend, 8'h11);
        chk_a("nopre.req", 1'b1, 1'b0, 4'd5, 1'b0);
        // Disabling the presented source drops the request
        a_en = 8'hEF;
        tick();
        chk_a("drop.idle", 1'b0, 1'b0, 4'd0, 1'b0);
        chk("drop.pend", a_pend, 8'h11);
        tick();
        chk_a("drop.next", 1'b1, 1'b1, 4'd1, 1'b0);
        a_en = 8'hFF;
        // Re-trigger race on source 0: new edge with the claim.
        a_src = 8'h10;
        tick();
        a_src = 8'h11; a_claim = 1'b1;
        tick();
        a_claim = 1'b0;
        chk("race.pend", a_pend, 8'h11);
        chk("race.state", {6'd0, a_state}, 8'd2);
        a_complete = 1'b1;
        tick();
        a_complete = 1'b0;
        tick();
        chk_a("race.rereq", 1'b1, 1'b1, 4'd1, 1'b0);
        a_claim = 1'b1;
        tick();
        a_claim = 1'b0;
        a_complete = 1'b1;
        tick();
        a_complete = 1'b0;
        tick();
        chk_a("race.src4", 1'b1, 1'b1, 4'd5, 1'b0);
        a_claim = 1'b1;
        tick();
        a_claim = 1'b0;
        a_complete = 1'b1;
        tick();
        a_complete = 1'b0;
        tick();
        chk_a("race.done", 1'b0, 1'b0, 4'd0, 1'b0);
        chk("race.pend_end", a_pend, 8'h00);

        // Level source 0 on the second instance.
        b_src = 8'h01;
        tick();
        chk("lvl.pend", b_pend, 8'h01);
        tick();
        chk("lvl.req_vec", {4'd0, b_vec}, 8'd1);
        chk("lvl.req_eirq", {7'd0, b_e_irq}, 8'd1);
        b_claim = 1'b1;
        tick();
        b_claim = 1'b0;
        chk("lvl.svc_busy", {7'd0, b_busy}, 8'd1);
        chk("lvl.svc_pend", b_pend, 8'h01);
        b_src = 8'h00;
        tick();
        chk("lvl.svc_hold", b_pend, 8'h01);
        b_src = 8'h01; b_complete = 1'b1;
        tick();
        b_complete = 1'b0;
        chk("lvl.idle_meip", {7'd0, b_meip}, 8'd0);
        chk("lvl.idle_state", {6'd0, b_state}, 8'd0);
        tick();
        chk("lvl.rereq_meip", {7'd0, b_meip}, 8'd1);
        chk("lvl.rereq_eirq", {7'd0, b_e_irq}, 8'd1);
        b_src = 8'h00;
        tick();
        chk("lvl.drop_pend", b_pend, 8'h00);
        chk("lvl.drop_still", {7'd0, b_meip}, 8'd1);
        tick();
        chk("lvl.drop_meip", {7'd0, b_meip}, 8'd0);
        chk("lvl.drop_vec", {4'd0, b_vec}, 8'd0);

        // Reset mid-request clears everything.
        a_src = 8'h80;
        tick(2);
        chk("mid.req_vec", {4'd0, a_vec}, 8'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_a("mid.rst", 1'b0, 1'b0, 4'd0, 1'b0);
        chk("mid.pend", a_pend, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
